key_entry_decoder: RTL and testbench
====================================

Name: key_entry_decoder

Overview:
- Consumer end of the keypad scanner interface: takes the scanner's `key_value`/`press` pair and turns discrete key presses into a confirmed numeric entry (e.g. charge minutes).
- Edge-detects `press`, accumulates up to MAX_DIGITS decimal digits, and handles confirm, clear and backspace keys.
- Presents the result to the charger control FSM with a valid/ack handshake, and drives BCD digits for the display.

Parameters:
- MAX_DIGITS, 2, maximum digits accepted (value range 0..99).
- VAL_W, 7, width of the binary `value` output; must hold 10^MAX_DIGITS-1.
- TIMEOUT_CYCLES, 10000, idle clock cycles in ENTRY before the entry is abandoned (10 s at 1 kHz).

Ports:
- clk  input  1  system clock (1 kHz).
- rst_n  input  1  reset; active-low, asynchronous assert.
- key_value  input  4  key code from the scanner; valid while press=1.
- press  input  1  debounced key-held level from the scanner.
- num_ack  input  1  consumer accepts `value`; sampled only in DONE.
- value  output  VAL_W  binary accumulated number.
- bcd_tens  output  4  tens digit of the current entry.
- bcd_ones  output  4  ones digit of the current entry.
- digit_cnt  output  2  digits currently entered (0..MAX_DIGITS).
- num_valid  output  1  high in DONE; `value` stable.
- busy  output  1  high in ENTRY or DONE.
- timeout  output  1  one-cycle pulse when an entry is abandoned.
- key_err  output  1  one-cycle pulse on a rejected key.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; value, bcd_tens, bcd_ones, digit_cnt = 0; num_valid, busy, timeout, key_err = 0; timeout counter = 0; press_d = 1.
  - press_d resets to 1 so a key held through reset release is not counted.
- Key event: `ev = press & ~press_d`, where press_d is registered `press`. One event per press regardless of hold length (a 4 s hold yields one event). key_value is sampled in the same cycle as ev.
- Latency: all outputs update on the clock edge that samples ev; visible 1 cycle after `press` is first sampled high.
- Key codes: 0-9 digit, 4'hA CONFIRM, 4'hB CLEAR, 4'hC BACKSPACE, 4'hD-4'hF unused.
- IDLE:
  - ev with a digit d: value=d, bcd_ones=d, bcd_tens=0, digit_cnt=1, go to ENTRY.
  - Any other ev: key_err pulse, stay in IDLE.
- ENTRY:
  - Digit, digit_cnt<MAX_DIGITS: value=value*10+d, bcd_tens=bcd_ones, bcd_ones=d, digit_cnt+1.
  - Digit, digit_cnt=MAX_DIGITS: ignored, key_err pulse.
  - CONFIRM: go to DONE, num_valid=1. Leading zeros are legal ("0","5" confirms as 5).
  - CLEAR: zero value, BCD and digit_cnt; go to IDLE.
  - BACKSPACE: value=value/10, bcd_ones=bcd_tens, bcd_tens=0, digit_cnt-1. If digit_cnt becomes 0, go to IDLE.
  - Unused code: key_err pulse.
  - Timeout counter: cleared on every ev; increments each cycle otherwise. When it reaches TIMEOUT_CYCLES-1, clear the entry, pulse timeout, go to IDLE.
- DONE:
  - All key events ignored; no key_err.
  - num_ack=1: go to IDLE next edge, clear value/BCD/digit_cnt, num_valid=0.
  - A key event in the same cycle as num_ack is dropped.
- busy = (state != IDLE).
- Reset mid-entry or in DONE: immediate return to reset values; nothing is reported.
- Arithmetic: value*10 is computed in VAL_W+4 bits and truncated. No overflow is possible given the MAX_DIGITS guard.

Decomposition:
- Shared package `keypad_pkg`:
  - key code constants KEY_CONFIRM=4'hA, KEY_CLEAR=4'hB, KEY_BACKSPACE=4'hC;
  - state enum {IDLE, ENTRY, DONE};
  - 4-bit key code typedef, shared with Keyboard_Scanner.
- One natural sub-module, `key_edge_detect`: press_d register plus ev generation, reset value 1.
- Digit accumulation and the FSM stay in the top module.

Test Plan:
- Press 4 (hold 100 cycles), 2, CONFIRM → value=42, bcd_tens=4, bcd_ones=2, num_valid=1. num_ack=1 → IDLE, value=0.
- Hold 7 for 4000 cycles then CONFIRM → value=7, digit_cnt=1 (one event only).
- 1,2,3 → third digit gives key_err pulse, value=12. BACKSPACE → value=1. BACKSPACE → IDLE, busy=0.
- Digit 5, then no key for TIMEOUT_CYCLES → timeout pulse exactly once, value=0, state IDLE.
- press=1 with key 9 held across rst_n release → no event. Release and re-press 9 → value=9.
- In DONE, key 3 and num_ack=1 in the same cycle → IDLE, value=0, key 3 dropped. CONFIRM in IDLE → key_err.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, entry FSM states and key classification.
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_CONFIRM   = 4'hA;
  localparam key_code_t KEY_CLEAR     = 4'hB;
  localparam key_code_t KEY_BACKSPACE = 4'hC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Codes 0..9 are numeric digits; everything above is a command or unused.
  function automatic logic is_digit(key_code_t k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for the scanner's debounced press level. The history
// register resets high so a key held through reset release yields no event.
module key_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic press_i,
  output logic ev_o
);

  logic press_q;

  // Remember last cycle's press level; reset high to mask held keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q <= 1'b1;
    end else begin
      press_q <= press_i;
    end
  end

  assign ev_o = press_i & ~press_q;

endmodule

// File: rtl/key_entry_decoder.sv
// Keypad entry decoder: turns key press events into a confirmed decimal
// number (up to MAX_DIGITS digits) with confirm/clear/backspace handling,
// an inactivity timeout, and a valid/ack handoff to the consumer.
module key_entry_decoder
  import keypad_pkg::*;
#(
  parameter int MAX_DIGITS     = 2,
  parameter int VAL_W          = 7,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key_value,
  input  logic             press,
  input  logic             num_ack,
  output logic [VAL_W-1:0] value,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic [1:0]       digit_cnt,
  output logic             num_valid,
  output logic             busy,
  output logic             timeout,
  output logic             key_err
);

  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       CNT_MAX  = 2'(MAX_DIGITS);

  logic ev_s;

  state_t           state_q, state_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic [1:0]       digit_cnt_q, digit_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             num_valid_q, num_valid_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic             key_err_q, key_err_d;

  // value*10 + d in a widened intermediate, then truncated back to VAL_W.
  logic [VAL_W+3:0] value_ext_s;
  logic [VAL_W+3:0] value_x10_s;

  key_edge_detect u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .press_i (press),
    .ev_o    (ev_s)
  );

  assign value_ext_s = {4'd0, value_q};
  assign value_x10_s = (value_ext_s << 3) + (value_ext_s << 1)
                     + {{VAL_W{1'b0}}, key_value};

  // Entry FSM: next state, accumulator update, timeout and error pulses.
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    digit_cnt_d = digit_cnt_q;
    tmo_d       = tmo_q;
    timeout_d   = 1'b0;
    key_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (ev_s) begin
          if (is_digit(key_value)) begin
            value_d     = VAL_W'(key_value);
            ones_d      = key_value;
            tens_d      = 4'd0;
            digit_cnt_d = 2'd1;
            state_d     = ENTRY;
          end else begin
            key_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ENTRY: begin
        if (ev_s) begin
          tmo_d = '0;
          if (is_digit(key_value)) begin
            if (digit_cnt_q < CNT_MAX) begin
              value_d     = value_x10_s[VAL_W-1:0];
              tens_d      = ones_q;
              ones_d      = key_value;
              digit_cnt_d = digit_cnt_q + 2'd1;
            end else begin
              key_err_d = 1'b1;
            end
          end else begin
            case (key_value)
              KEY_CONFIRM: begin
                state_d = DONE;
              end
              KEY_CLEAR: begin
                value_d     = '0;
                tens_d      = 4'd0;
                ones_d      = 4'd0;
                digit_cnt_d = 2'd0;
                state_d     = IDLE;
              end
              KEY_BACKSPACE: begin
                value_d     = value_q / VAL_W'(10);
                ones_d      = tens_q;
                tens_d      = 4'd0;
                digit_cnt_d = digit_cnt_q - 2'd1;
                if (digit_cnt_q == 2'd1) begin
                  state_d = IDLE;
                end else begin
                  state_d = ENTRY;
                end
              end
              default: begin
                key_err_d = 1'b1;
              end
            endcase
          end
        end else if (tmo_q == TMO_LAST) begin
          value_d     = '0;
          tens_d      = 4'd0;
          ones_d      = 4'd0;
          digit_cnt_d = 2'd0;
          tmo_d       = '0;
          timeout_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      DONE: begin
        tmo_d = '0;
        // Key events are ignored here, including one coincident with ack.
        if (num_ack) begin
          value_d     = '0;
          tens_d      = 4'd0;
          ones_d      = 4'd0;
          digit_cnt_d = 2'd0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        value_d     = '0;
        tens_d      = 4'd0;
        ones_d      = 4'd0;
        digit_cnt_d = 2'd0;
        tmo_d       = '0;
        state_d     = IDLE;
      end
    endcase

    num_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      value_q     <= '0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      digit_cnt_q <= 2'd0;
      tmo_q       <= '0;
      num_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      digit_cnt_q <= digit_cnt_d;
      tmo_q       <= tmo_d;
      num_valid_q <= num_valid_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      key_err_q   <= key_err_d;
    end
  end

  assign value     = value_q;
  assign bcd_tens  = tens_q;
  assign bcd_ones  = ones_q;
  assign digit_cnt = digit_cnt_q;
  assign num_valid = num_valid_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign key_err   = key_err_q;

endmodule

// File: tb/tb_key_entry_decoder.sv
// Directed, table-driven bench for key_entry_decoder plus hand-written
// multi-cycle sequences (long hold, timeout, ack collision, held reset).
module tb_key_entry_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_value;
  logic       press;
  logic       num_ack;
  logic [6:0] value;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [1:0] digit_cnt;
  logic       num_valid;
  logic       busy;
  logic       timeout;
  logic       key_err;

  int total = 0;
  int bad   = 0;

  key_entry_decoder #(
    .MAX_DIGITS     (2),
    .VAL_W          (7),
    .TIMEOUT_CYCLES (10000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_value (key_value),
    .press     (press),
    .num_ack   (num_ack),
    .value     (value),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .digit_cnt (digit_cnt),
    .num_valid (num_valid),
    .busy      (busy),
    .timeout   (timeout),
    .key_err   (key_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    logic       prs;
    logic       ack;
    int         v;
    int         t;
    int         o;
    int         c;
    logic       nv;
    logic       bz;
    logic       err;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int v, input int t, input int o,
                         input int c, input int nv, input int bz, input int err);
    chk({tag, "_value"}, int'(value), v);
    chk({tag, "_tens"},  int'(bcd_tens), t);
    chk({tag, "_ones"},  int'(bcd_ones), o);
    chk({tag, "_cnt"},   int'(digit_cnt), c);
    chk({tag, "_valid"}, int'(num_valid), nv);
    chk({tag, "_busy"},  int'(busy), bz);
    chk({tag, "_err"},   int'(key_err), err);
  endtask

  // Press a key for one cycle, then release for one cycle.
  task automatic tap(input logic [3:0] k);
    key_value = k;
    press     = 1'b1;
    tick();
    press     = 1'b0;
    tick();
  endtask

  initial begin
    int pulses;
    int first_n;

    rst_n     = 1'b0;
    key_value = 4'd0;
    press     = 1'b0;
    num_ack   = 1'b0;

    //            key    prs   ack   v   t  o  c  nv    bz    err
    tbl[0]  = '{4'h4, 1'b1, 1'b0,  4, 0, 4, 1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{4'h2, 1'b1, 1'b0, 42, 4, 2, 2, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{4'hA, 1'b1, 1'b0, 42, 4, 2, 2, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{4'h0, 1'b0, 1'b1,  0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'hA, 1'b1, 1'b0,  0, 0, 0, 0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{4'h1, 1'b1, 1'b0,  1, 0, 1, 1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{4'h2, 1'b1, 1'b0, 12, 1, 2, 2, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{4'h3, 1'b1, 1'b0, 12, 1, 2, 2, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{4'hC, 1'b1, 1'b0,  1, 0, 1, 1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{4'hC, 1'b1, 1'b0,  0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{4'h0, 1'b1, 1'b0,  0, 0, 0, 1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{4'h5, 1'b1, 1'b0,  5, 0, 5, 2, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{4'hE, 1'b1, 1'b0,  5, 0, 5, 2, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{4'hA, 1'b1, 1'b0,  5, 0, 5, 2, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{4'h7, 1'b1, 1'b0,  5, 0, 5, 2, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{4'h0, 1'b0, 1'b1,  0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{4'h9, 1'b1, 1'b0,  9, 0, 9, 1, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{4'hB, 1'b1, 1'b0,  0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{4'hF, 1'b1, 1'b0,  0, 0, 0, 0, 1'b0, 1'b0, 1'b1};

    // Reset state
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset_timeout", int'(timeout), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven vectors: one action cycle, then one idle cycle.
    for (int i = 0; i < 19; i++) begin
      key_value = tbl[i].key;
      press     = tbl[i].prs;
      num_ack   = tbl[i].ack;
      tick();
      chk_all($sformatf("v%0d", i), tbl[i].v, tbl[i].t, tbl[i].o, tbl[i].c,
              int'(tbl[i].nv), int'(tbl[i].bz), int'(tbl[i].err));
      press   = 1'b0;
      num_ack = 1'b0;
      tick();
      chk($sformatf("v%0d_err_clr", i), int'(key_err), 0);
      chk($sformatf("v%0d_valid_hold", i), int'(num_valid), int'(tbl[i].nv));
    end

    // Long hold of 7 counts as a single digit.
    key_value = 4'h7;
    press     = 1'b1;
    for (int n = 0; n < 4000; n++) tick();
    chk("hold7_cnt", int'(digit_cnt), 1);
    chk("hold7_val", int'(value), 7);
    press = 1'b0;
    tick();
    tap(4'hA);
    chk_all("hold7_done", 7, 0, 7, 1, 1, 1, 0);
    num_ack = 1'b1;
    tick();
    num_ack = 1'b0;
    chk("hold7_ack_busy", int'(busy), 0);

    // Key event coincident with ack in DONE is dropped.
    tap(4'h6);
    tap(4'hA);
    chk("coll_pre_valid", int'(num_valid), 1);
    key_value = 4'h3;
    press     = 1'b1;
    num_ack   = 1'b1;
    tick();
    chk_all("coll", 0, 0, 0, 0, 0, 0, 0);
    num_ack = 1'b0;
    tick();
    chk("coll_hold_busy", int'(busy), 0);
    chk("coll_hold_val", int'(value), 0);
    press = 1'b0;
    tick();
    tap(4'hA);
    key_value = 4'hA;
    press     = 1'b1;
    tick();
    chk("idle_confirm_err", int'(key_err), 1);
    press = 1'b0;
    tick();

    // Inactivity timeout: pulse once, exactly 10000 cycles after the event.
    key_value = 4'h5;
    press     = 1'b1;
    tick();
    chk("tmo_start_val", int'(value), 5);
    pulses  = 0;
    first_n = -1;
    for (int n = 1; n <= 10100; n++) begin
      press = 1'b0;
      tick();
      if (timeout) begin
        pulses++;
        if (first_n < 0) first_n = n;
      end
    end
    chk("tmo_pulses", pulses, 1);
    chk("tmo_cycle", first_n, 10000);
    chk_all("tmo_after", 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-entry with a key held through reset release.
    tap(4'h8);
    chk("rst_pre_busy", int'(busy), 1);
    key_value = 4'h9;
    press     = 1'b1;
    tick();
    chk("rst_pre_val", int'(value), 89);
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk_all("rst_held", 0, 0, 0, 0, 0, 0, 0);
    press = 1'b0;
    tick();
    key_value = 4'h9;
    press     = 1'b1;
    tick();
    chk_all("rst_repress", 9, 0, 9, 1, 0, 1, 0);
    press = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
